// File: rtl/dct2d_param.sv
// Purpose : 2-D DCT / IDCT of an NxN block using one signed MAC, run as two
//           separable passes (T = C'.X, then R = T.C'^T) over a single multiplier.
// Latency : done rises 2*N^3+1 edges after the start-accepting edge; busy is high
//           whenever the FSM is out of IDLE.
// Backpressure: none; start is only honoured in IDLE and is neither queued nor
//           held, and dct_out/sat hold their values between done pulses.
// Ports   : clk, reset (async, active-low), start, inv (0 = forward, 1 = inverse),
//           mcu[row][col] input block; dct_out[row][col], busy, done, sat outputs.
module dct2d_param #(
   parameter int N     = 8,   // block edge, 4 or 8
   parameter int DW    = 32,  // signed sample width
   parameter int CW    = 16,  // signed coefficient width
   parameter int CFRAC = 14   // coefficient fractional bits
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         inv,
   input  logic [N-1:0][N-1:0][DW-1:0]  mcu,
   output logic [N-1:0][N-1:0][DW-1:0]  dct_out,
   output logic                         busy,
   output logic                         done,
   output logic                         sat
);

   localparam int  LN   = $clog2(N);
   localparam int  CNTW = 3 * LN;
   localparam int  AW   = DW + CW + LN;
   localparam real PI   = 3.14159265358979323846;

   // C[k][n] = round(2^CFRAC * a(k) * cos((2n+1)k*pi/2N)), rounded half away from zero
   // so that mirrored coefficients cancel exactly.
   function automatic logic [N*N*CW-1:0] gen_rom();
      logic [N*N*CW-1:0] rom;
      real               a;
      real               x;
      int                v;
      rom = '0;
      for (int k = 0; k < N; k++) begin
         for (int n = 0; n < N; n++) begin
            a = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
            x = a * $cos((2 * n + 1) * k * PI / (2.0 * N)) * (2.0 ** CFRAC);
            v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
            rom[(k * N + n) * CW +: CW] = v[CW-1:0];
         end
      end
      return rom;
   endfunction

   localparam logic [N*N*CW-1:0] C_ROM = gen_rom();
   localparam logic signed [AW:0] RND  = {{(AW + 1 - CFRAC){1'b0}}, 1'b1, {(CFRAC - 1){1'b0}}};
   localparam logic signed [AW:0] MAXV = {{(AW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
   localparam logic signed [AW:0] MINV = {{(AW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

   state_t                         r_state;
   state_t                         w_next;
   logic [CNTW-1:0]                r_cnt;
   logic [N-1:0][N-1:0][DW-1:0]    r_x;    // captured input; reused to hold R in PASS2
   logic [N-1:0][N-1:0][DW-1:0]    r_t;    // first-pass result
   logic                           r_inv;
   logic                           r_sat_stk;
   logic signed [AW-1:0]           r_acc;

   logic [LN-1:0]                  w_i, w_j, w_k, w_row;
   logic [2*LN-1:0]                w_cidx;
   logic                           w_last;
   logic signed [CW-1:0]           w_coef;
   logic signed [DW-1:0]           w_opd;
   logic signed [DW+CW-1:0]        w_prod;
   logic signed [AW-1:0]           w_base, w_sum;
   logic signed [AW:0]             w_rnd, w_shf;
   logic                           w_ovf;
   logic [DW-1:0]                  w_res;

   // Loop nest i (outer), j, k (inner) packed into one counter.
   assign w_i    = r_cnt[3*LN-1:2*LN];
   assign w_j    = r_cnt[2*LN-1:LN];
   assign w_k    = r_cnt[LN-1:0];
   assign w_last = &r_cnt;
   assign busy   = (r_state != IDLE);

   // PASS1 needs C'[i][k]*X[k][j]; PASS2 needs T[i][k]*C'[j][k]. C' = C^T in inverse
   // mode, which is just a swap of the ROM row/column index.
   always_comb begin
      w_row  = (r_state == PASS2) ? w_j : w_i;
      w_cidx = r_inv ? {w_k, w_row} : {w_row, w_k};
      w_coef = C_ROM[w_cidx * CW +: CW];
      w_opd  = (r_state == PASS2) ? r_t[w_i][w_k] : r_x[w_k][w_j];
   end

   assign w_prod = w_opd * w_coef;
   assign w_base = (w_k == '0) ? '0 : r_acc;
   assign w_sum  = w_base + {{LN{w_prod[DW+CW-1]}}, w_prod};

   // Element finalisation: round half-up, arithmetic shift, clamp to DW.
   assign w_rnd  = $signed({w_sum[AW-1], w_sum}) + RND;
   assign w_shf  = w_rnd >>> CFRAC;
   assign w_ovf  = (w_shf > MAXV) || (w_shf < MINV);
   assign w_res  = w_ovf ? (w_shf[AW] ? MINV[DW-1:0] : MAXV[DW-1:0]) : w_shf[DW-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start)  w_next = PASS1;
         PASS1:   if (w_last) w_next = PASS2;
         PASS2:   if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_x       <= '0;
         r_t       <= '0;
         r_inv     <= 1'b0;
         r_sat_stk <= 1'b0;
         r_acc     <= '0;
         dct_out   <= '0;
         done      <= 1'b0;
         sat       <= 1'b0;
      end else begin
         done <= (r_state == DONE);
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_x       <= mcu;
                  r_inv     <= inv;
                  r_cnt     <= '0;
                  r_sat_stk <= 1'b0;
               end
            end
            PASS1, PASS2: begin
               r_cnt <= r_cnt + CNTW'(1);
               r_acc <= w_sum;
               if (w_k == LN'(N - 1)) begin
                  if (r_state == PASS1) r_t[w_i][w_j] <= w_res;
                  else                  r_x[w_i][w_j] <= w_res;
                  if (w_ovf) r_sat_stk <= 1'b1;
               end
            end
            DONE: begin
               // dct_out is only touched here, so an abort never leaves a partial block.
               dct_out <= r_x;
               sat     <= r_sat_stk;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dct2d_param.md
DCT2D_PARAM -- requirements
Module: dct2d_param

Interface
REQ-001 The block SHALL expose parameter N, default 8, giving the block edge length; legal values are 4 and 8.
REQ-002 The block SHALL expose parameter DW, default 32, giving the signed sample width for input, intermediate and output.
REQ-003 The block SHALL expose parameter CW, default 16, giving the signed coefficient width.
REQ-004 The block SHALL expose parameter CFRAC, default 14, giving the number of coefficient fractional bits.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: request to transform mcu.
REQ-008 The block SHALL have port inv, input, 1 bit: mode select, 0 for forward DCT and 1 for inverse DCT; it is sampled together with start.
REQ-009 The block SHALL have port mcu, input, [N-1:0][N-1:0][DW-1:0]: input block in [row][col] order, signed.
REQ-010 The block SHALL have port dct_out, output, [N-1:0][N-1:0][DW-1:0]: result block in [row][col] order, signed, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: a single-cycle pulse marking that dct_out has been updated.
REQ-013 The block SHALL have port sat, output, 1 bit: set if any value saturated during the last transform.

Function
REQ-014 Coefficient ROM: C[k][n] SHALL equal round(2^CFRAC * a(k) * cos((2n+1)kπ/2N)), with a(0)=sqrt(1/N), a(k>0)=sqrt(2/N), rounded to nearest, symmetric about zero; the ROM is generated at elaboration.
REQ-015 Forward mode SHALL compute Y = C·X·Cᵀ; inverse mode SHALL compute X = Cᵀ·Y·C.
REQ-016 The FSM SHALL have states IDLE, PASS1, PASS2 and DONE.
REQ-017 FSM transitions: IDLE→PASS1 on start=1; PASS1→PASS2 after N³ cycles; PASS2→DONE after N³ cycles; DONE→IDLE unconditionally.
REQ-018 On the edge that accepts start, mcu and inv SHALL be captured into internal registers; later changes to mcu or inv SHALL have no effect on the transform in progress.
REQ-019 PASS1 SHALL perform one signed MAC per cycle, computing T[i][j] = Σk C'[i][k]·Xin[k][j], where C' is C in forward mode and Cᵀ in inverse mode; loop order is i outer, j, then k inner.
REQ-020 PASS2 SHALL perform one MAC per cycle, computing R[i][j] = Σk T[i][k]·C'[j][k], with the same loop order.
REQ-021 The accumulator SHALL be DW+CW+clog2(N) bits wide and SHALL clear at k=0 of each element.
REQ-022 At the end of each element, the block SHALL add 2^(CFRAC-1), arithmetic-shift right by CFRAC, and saturate to the signed DW range; any saturation SHALL set the internal sticky sat flag.
REQ-023 T SHALL be stored at DW bits after the rounding and saturation of REQ-022.
REQ-024 On entry to DONE, dct_out SHALL be loaded with R, sat SHALL be updated, and done SHALL be 1 for exactly one cycle.
REQ-025 Latency: done SHALL be high on the cycle following edge 2·N³+1 counted from the start-accepting edge, i.e. 1025 edges for N=8.
REQ-026 start SHALL be ignored in PASS1, PASS2 and DONE; it is not queued.
REQ-027 A start held high continuously SHALL launch a new transform on each return to IDLE.
REQ-028 dct_out and sat SHALL hold their values between done pulses.

Reset
REQ-029 While reset is 0, regardless of clk: state=IDLE, busy=0, done=0, sat=0, dct_out is all zero, and counters and accumulator are cleared.
REQ-030 Assertion of reset mid-transform SHALL abort the transform with no partial update of dct_out.
REQ-031 After reset is released, the first start SHALL see the full latency of REQ-025.

Verification
REQ-032 Scenario 1: N=8, forward, all mcu = 256 → dct_out[0][0] = 2048, all other 63 outputs = 0, sat=0, done high 1025 edges after start.
REQ-033 Scenario 2: N=8, forward, columns alternating 32'hff00/0 in every row → all of rows 1..7 = 0; row 0 even columns 2, 4, 6 = 0; dct_out[0][0] = 261120 ±2; row 0 odd columns nonzero.
REQ-034 Scenario 3: Random block with values in [-2048, 2047], forward then inverse → every element equals the original ±2, sat=0.
REQ-035 Scenario 4: start pulsed during PASS1 and mcu changed after acceptance → exactly one done, and the result matches the originally captured block.
REQ-036 Scenario 5: reset driven low mid-PASS2 → busy, done, sat and dct_out immediately 0; a subsequent start completes in 1025 edges with a correct result.
REQ-037 Scenario 6: DW=16, N=8, all mcu = 32767, forward → dct_out[0][0] = 32767, sat=1.
